alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 55 +++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface alu_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_op;
    logic [7:0] req0_a;
    logic [7:0] req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_op;
    logic [7:0] req1_a;
    logic [7:0] req1_b;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic [7:0] rsp_result2;
    logic [3:0] rsp_flags;
    logic       rsp_carry;
    logic       rsp_err;

    logic [7:0] alu_operand_a;
    logic [7:0] alu_operand_b;
    logic [1:0] alu_operation;
    logic       alu_enable;
    logic [7:0] alu_result;
    logic [7:0] alu_result2;
    logic [3:0] alu_flags;
    logic       alu_carry_out;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_result2, rsp_flags, rsp_carry, rsp_err,
        input  rsp_ready,
        output alu_operand_a, alu_operand_b, alu_operation, alu_enable,
        input  alu_result, alu_result2, alu_flags, alu_carry_out
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_result2, rsp_flags, rsp_carry, rsp_err,
        output rsp_ready,
        input  alu_operand_a, alu_operand_b, alu_operation, alu_enable,
        output alu_result, alu_result2, alu_flags, alu_carry_out
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ALU between two requesters.
// Optional macro ALU_ARB_DIVZERO_CHECK_EN: DIV by zero bypasses the ALU and responds with rsp_err.
module alu_arbiter #(
    parameter int unsigned LAT_ADDSUB = 1,
    parameter int unsigned LAT_MULT   = 4,
    parameter int unsigned LAT_DIV    = 8
) (
    input logic           CLK,
    input logic           RESET,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       prio;
    logic       owner;
    logic [3:0] cnt;
    logic [7:0] opa_q, opb_q;
    logic [1:0] op_q;
    logic       en_q;
    logic       rv_q, rid_q, rc_q;
    logic [7:0] rr_q, rr2_q;
    logic [3:0] rf_q;

    logic       grant0, grant1, idle_ok, accept, sel;
    logic [1:0] sel_op;
    logic [7:0] sel_a, sel_b;

    function automatic logic [3:0] lat_of(input logic [1:0] op);
        case (op)
            2'b10:   return 4'(LAT_MULT);
            2'b11:   return 4'(LAT_DIV);
            default: return 4'(LAT_ADDSUB);
        endcase
    endfunction

    // Priority holder wins a tie; a lone valid wins regardless of priority.
    always_comb begin
        grant0  = bus.req0_valid && (!prio || !bus.req1_valid);
        grant1  = bus.req1_valid && (prio || !bus.req0_valid);
        idle_ok = (state == IDLE) && !RESET;
        accept  = idle_ok && (grant0 || grant1);
        sel     = grant1;
        sel_op  = grant1 ? bus.req1_op : bus.req0_op;
        sel_a   = grant1 ? bus.req1_a  : bus.req0_a;
        sel_b   = grant1 ? bus.req1_b  : bus.req0_b;
    end

    assign bus.req0_ready    = idle_ok && grant0;
    assign bus.req1_ready    = idle_ok && grant1;
    assign bus.alu_operand_a = opa_q;
    assign bus.alu_operand_b = opb_q;
    assign bus.alu_operation = op_q;
    assign bus.alu_enable    = en_q;
    assign bus.rsp_valid     = rv_q;
    assign bus.rsp_id        = rid_q;
    assign bus.rsp_result    = rr_q;
    assign bus.rsp_result2   = rr2_q;
    assign bus.rsp_flags     = rf_q;
    assign bus.rsp_carry     = rc_q;

`ifdef ALU_ARB_DIVZERO_CHECK_EN
    logic err_q;
    logic div_zero;
    assign div_zero    = (sel_op == 2'b11) && (sel_b == '0);
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            cnt   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= '0;
            en_q  <= 1'b0;
            rv_q  <= 1'b0;
            rid_q <= 1'b0;
            rr_q  <= '0;
            rr2_q <= '0;
            rf_q  <= '0;
            rc_q  <= 1'b0;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    owner <= sel;
                    prio  <= ~sel;
                    opa_q <= sel_a;
                    opb_q <= sel_b;
                    op_q  <= sel_op;
                    cnt   <= lat_of(sel_op);
`ifdef ALU_ARB_DIVZERO_CHECK_EN
                    if (div_zero) begin
                        state <= RESP;
                        rv_q  <= 1'b1;
                        rid_q <= sel;
                        rr_q  <= '0;
                        rr2_q <= '0;
                        rf_q  <= '0;
                        rc_q  <= 1'b0;
                        err_q <= 1'b1;
                    end else begin
                        state <= ISSUE;
                        en_q  <= 1'b1;
                    end
`else
                    state <= ISSUE;
                    en_q  <= 1'b1;
`endif
                end
                // cnt holds edges still to elapse; capture on the edge where it reaches one.
                ISSUE, WAIT: begin
                    en_q <= 1'b0;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        rv_q  <= 1'b1;
                        rid_q <= owner;
                        rr_q  <= bus.alu_result;
                        rr2_q <= bus.alu_result2;
                        rf_q  <= bus.alu_flags;
                        rc_q  <= bus.alu_carry_out;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
                        err_q <= 1'b0;
`endif
                    end else begin
                        cnt   <= cnt - 4'd1;
                        state <= WAIT;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    rv_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU on the shared port.
// Honours ALU_ARB_DIVZERO_CHECK_EN when choosing the divide-by-zero expectations.
module tb_alu_arbiter;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    alu_arbiter_if bus();

    alu_arbiter #(
        .LAT_ADDSUB (1),
        .LAT_MULT   (4),
        .LAT_DIV    (8)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Behavioural ALU: flags = {negative, zero, 0, carry}.
    logic [7:0]         m_r, m_r2;
    logic               m_c;
    logic signed [15:0] m_p;
    always_comb begin
        m_r  = '0;
        m_r2 = '0;
        m_c  = 1'b0;
        m_p  = '0;
        case (bus.alu_operation)
            2'b00: {m_c, m_r} = {1'b0, bus.alu_operand_a} + {1'b0, bus.alu_operand_b};
            2'b01: {m_c, m_r} = {1'b0, bus.alu_operand_a} - {1'b0, bus.alu_operand_b};
            2'b10: begin
                m_p  = $signed(bus.alu_operand_a) * $signed(bus.alu_operand_b);
                m_r  = m_p[7:0];
                m_r2 = m_p[15:8];
            end
            default: begin
                if (bus.alu_operand_b != '0) begin
                    m_r  = $signed(bus.alu_operand_a) / $signed(bus.alu_operand_b);
                    m_r2 = $signed(bus.alu_operand_a) % $signed(bus.alu_operand_b);
                end else begin
                    m_r  = 8'hFF;
                    m_r2 = bus.alu_operand_a;
                end
            end
        endcase
    end
    assign bus.alu_result    = m_r;
    assign bus.alu_result2   = m_r2;
    assign bus.alu_carry_out = m_c;
    assign bus.alu_flags     = {m_r[7], (m_r == 8'h00), 1'b0, m_c};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic accept(input string t, input int id);
        check({t, "_ready"}, (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
        check({t, "_other_ready"}, (id == 0) ? bus.req1_ready : bus.req0_ready, 0);
        tick();
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
    endtask

    // Accept, wait for the response, check it, optionally release it.
    task automatic serve(input string t, input int id, input logic [1:0] op, input logic [7:0] a,
                         input int lat, input logic [7:0] r, input logic [7:0] r2,
                         input logic [3:0] fl, input logic c, input int en, input logic err,
                         input bit do_pop);
        int cycles, enables, unstable;
        accept(t, id);
        cycles = 0; enables = 0; unstable = 0;
        while (!bus.rsp_valid && cycles < 40) begin
            if (bus.alu_enable) enables++;
            if (bus.alu_operand_a !== a || bus.alu_operation !== op) unstable++;
            if (bus.req0_ready || bus.req1_ready) unstable++;
            tick();
            cycles++;
        end
        check({t, "_rsp_valid"}, bus.rsp_valid, 1);
        check({t, "_latency"}, cycles, lat);
        check({t, "_enable_pulses"}, enables, en);
        check({t, "_busy_stable"}, unstable, 0);
        check({t, "_rsp_id"}, bus.rsp_id, id);
        check({t, "_result"}, bus.rsp_result, r);
        check({t, "_result2"}, bus.rsp_result2, r2);
        check({t, "_flags"}, bus.rsp_flags, fl);
        check({t, "_carry"}, bus.rsp_carry, c);
        check({t, "_err"}, bus.rsp_err, err);
        check({t, "_enable_in_resp"}, bus.alu_enable, 0);
        if (do_pop) begin
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            check({t, "_released"}, bus.rsp_valid, 0);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        int seen;
        RESET = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;
        tick();
        tick();

        // Reset state; ready must stay low while RESET is high even with requests pending.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_enable", bus.alu_enable, 0);
        check("rst_result", bus.rsp_result, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_err", bus.rsp_err, 0);
        check("rst_opa", bus.alu_operand_a, 0);
        check("rst_operation", bus.alu_operation, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        RESET = 1'b0;
        tick();

        // ADD -5 + -2 = -7
        set_req(0, 2'b00, 8'hFB, 8'hFE); #1;
        serve("add_neg", 0, 2'b00, 8'hFB, 1, 8'hF9, 8'h00, 4'b1001, 1'b1, 1, 1'b0, 1'b1);

        // Simultaneous requests after reset alternate req0, req1, req0, req1.
        do_reset();
        set_req(0, 2'b01, 8'hFD, 8'hFC);
        set_req(1, 2'b00, 8'h01, 8'h02); #1;
        serve("rr_a0", 0, 2'b01, 8'hFD, 1, 8'h01, 8'h00, 4'b0000, 1'b0, 1, 1'b0, 1'b1);
        serve("rr_a1", 1, 2'b00, 8'h01, 1, 8'h03, 8'h00, 4'b0000, 1'b0, 1, 1'b0, 1'b1);
        set_req(0, 2'b00, 8'h80, 8'h80);
        set_req(1, 2'b00, 8'h7F, 8'h01); #1;
        serve("rr_b0", 0, 2'b00, 8'h80, 1, 8'h00, 8'h00, 4'b0101, 1'b1, 1, 1'b0, 1'b1);
        serve("rr_b1", 1, 2'b00, 8'h7F, 1, 8'h80, 8'h00, 4'b1000, 1'b0, 1, 1'b0, 1'b1);

        // MULT 10*4 on req1, response left pending.
        set_req(1, 2'b10, 8'h0A, 8'h04); #1;
        serve("mul", 1, 2'b10, 8'h0A, 4, 8'h28, 8'h00, 4'b0000, 1'b0, 1, 1'b0, 1'b0);

        // Back-pressure: response held, no grants, while req0 waits.
        set_req(0, 2'b10, 8'hFD, 8'h05); #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, 8'h28);
            check("hold_id", bus.rsp_id, 1);
            check("hold_ready0", bus.req0_ready, 0);
            check("hold_ready1", bus.req1_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        serve("mul_neg", 0, 2'b10, 8'hFD, 4, 8'hF1, 8'hFF, 4'b1000, 1'b0, 1, 1'b0, 1'b1);

        // Reset in the third WAIT cycle of DIV 21/3 drops the operation.
        set_req(0, 2'b11, 8'h15, 8'h03); #1;
        accept("div_abort", 0);
        tick(); tick(); tick();
        do_reset();
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_enable", bus.alu_enable, 0);
        check("abort_opa", bus.alu_operand_a, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        check("abort_no_response", seen, 0);

        // Full DIV 21/3 after the abort.
        set_req(1, 2'b11, 8'h15, 8'h03); #1;
        serve("div", 1, 2'b11, 8'h15, 8, 8'h07, 8'h00, 4'b0000, 1'b0, 1, 1'b0, 1'b1);

        // DIV 21/0.
        set_req(0, 2'b11, 8'h15, 8'h00); #1;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
        serve("div0", 0, 2'b11, 8'h15, 0, 8'h00, 8'h00, 4'b0000, 1'b0, 0, 1'b1, 1'b1);
`else
        serve("div0", 0, 2'b11, 8'h15, 8, 8'hFF, 8'h15, 4'b1000, 1'b0, 1, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
